// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Registered RV32I ALU / branch comparator with iterative RV32M
//             multiply, divide and remainder (radix-2, one bit per cycle).
//             Valid/ready handshake on both the request and result sides.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      S,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Q,
    output logic            CMP,
    output logic            busy
);

    // Counter must be able to hold the value XLEN itself.
    localparam int                CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]     C_ITER   = CW'(XLEN);
    localparam logic [CW-1:0]     C_ONE    = CW'(1);
    localparam logic [XLEN-1:0]   C_ZERO   = '0;
    localparam logic [2*XLEN-1:0] C_ZERO2  = '0;

    // M-extension sub-operation codes, taken from S[4:2] when S[1:0]==2'b10.
    localparam logic [2:0] C_MUL    = 3'd0;
    localparam logic [2:0] C_MULH   = 3'd1;
    localparam logic [2:0] C_MULHSU = 3'd2;
    localparam logic [2:0] C_MULHU  = 3'd3;
    localparam logic [2:0] C_DIV    = 3'd4;
    localparam logic [2:0] C_DIVU   = 3'd5;
    localparam logic [2:0] C_REM    = 3'd6;
    localparam logic [2:0] C_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [XLEN-1:0] q_q, q_d;
    logic            cmp_q, cmp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      mop_q, mop_d;     // latched M sub-operation
    logic            neg_q, neg_d;     // negate the final magnitude result
    logic [XLEN-1:0] acc_q, acc_d;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;       // multiplier->product low / dividend->quotient
    logic [XLEN-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude

    // ------------------------------------------------------------------
    // Base ALU and branch comparator (single cycle)
    // ------------------------------------------------------------------
    logic [SHW-1:0]  shamt;
    logic            lt_s, lt_u, eq;
    logic [XLEN-1:0] base_q;
    logic            base_cmp;
    logic            is_mop;

    assign shamt  = B[SHW-1:0];
    assign lt_s   = $signed(A) < $signed(B);
    assign lt_u   = A < B;
    assign eq     = A == B;
    assign is_mop = S[1:0] == 2'b10;

    // Decode the base opcode; unknown codes fall through to zero results.
    always_comb begin
        base_q   = '0;
        base_cmp = 1'b0;
        if (S[1:0] == 2'b11) begin
            // Branch compares: S[5] ignored, condition chosen by S[4:2].
            case (S[4:2])
                3'd0:    base_cmp = eq;
                3'd1:    base_cmp = !eq;
                3'd4:    base_cmp = lt_s;
                3'd5:    base_cmp = !lt_s;
                3'd6:    base_cmp = lt_u;
                3'd7:    base_cmp = !lt_u;
                default: base_cmp = 1'b0;
            endcase
        end else begin
            case (S)
                6'd1:  base_q = A + B;
                6'd33: base_q = A - B;
                6'd29: base_q = A & B;
                6'd25: base_q = A | B;
                6'd17: base_q = A ^ B;
                6'd5:  base_q = A << shamt;
                6'd21: base_q = A >> shamt;
                6'd53: base_q = $signed(A) >>> shamt;
                6'd9: begin
                    base_q   = {{(XLEN-1){1'b0}}, lt_s};
                    base_cmp = lt_s;
                end
                6'd13: begin
                    base_q   = {{(XLEN-1){1'b0}}, lt_u};
                    base_cmp = lt_u;
                end
                default: begin
                    base_q   = '0;
                    base_cmp = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // M-operation setup: the datapath works on magnitudes, and the sign
    // is restored once at the end through neg_q.
    // ------------------------------------------------------------------
    logic            a_sgn, b_sgn, a_neg, b_neg, b_zero;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            init_neg;

    // Work out operand signedness, magnitudes and the final-negate flag.
    always_comb begin
        a_sgn  = (S[4:2] == C_MULH) || (S[4:2] == C_MULHSU) ||
                 (S[4:2] == C_DIV)  || (S[4:2] == C_REM);
        b_sgn  = (S[4:2] == C_MULH) || (S[4:2] == C_DIV) || (S[4:2] == C_REM);
        a_neg  = a_sgn && A[XLEN-1];
        b_neg  = b_sgn && B[XLEN-1];
        b_zero = B == C_ZERO;
        a_mag  = a_neg ? (C_ZERO - A) : A;
        b_mag  = b_neg ? (C_ZERO - B) : B;
        case (S[4:2])
            C_MULH, C_MULHSU: init_neg = a_neg ^ b_neg;
            // Divide by zero keeps the all-ones quotient un-negated.
            C_DIV:            init_neg = (a_neg ^ b_neg) && !b_zero;
            // Remainder takes the sign of the dividend.
            C_REM:            init_neg = a_neg;
            default:          init_neg = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply or restoring divide
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   acc_nx, lo_nx;

    // Compute the next accumulator / low-word pair for the latched op.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {1'b0, C_ZERO});
        div_sh  = {acc_q, lo_q[XLEN-1]};
        div_ge  = div_sh >= {1'b0, opnd_q};
        if (mop_q[2]) begin
            // When div_ge holds the true difference is below 2^XLEN,
            // so the low XLEN bits of the subtraction are exact.
            acc_nx = div_ge ? (div_sh[XLEN-1:0] - opnd_q) : div_sh[XLEN-1:0];
            lo_nx  = {lo_q[XLEN-2:0], div_ge};
        end else begin
            acc_nx = mul_sum[XLEN:1];
            lo_nx  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Final sign fix-up, applied to the last iteration's outputs
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    logic [XLEN-1:0]   m_res;

    // Select and sign-correct the M-operation result.
    always_comb begin
        prod     = {acc_nx, lo_nx};
        prod_fix = neg_q ? (C_ZERO2 - prod) : prod;
        quot_fix = neg_q ? (C_ZERO - lo_nx) : lo_nx;
        rem_fix  = neg_q ? (C_ZERO - acc_nx) : acc_nx;
        case (mop_q)
            C_MUL:                     m_res = prod_fix[XLEN-1:0];
            C_MULH, C_MULHSU, C_MULHU: m_res = prod_fix[2*XLEN-1:XLEN];
            C_DIV, C_DIVU:             m_res = quot_fix;
            default:                   m_res = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = state_q == ST_DONE;
    assign busy      = state_q == ST_BUSY;
    assign Q         = q_q;
    assign CMP       = cmp_q;

    logic accept;
    assign accept = in_valid && in_ready;

    // Next-state logic: flush wins, then iteration/retire, then accept.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        mop_d   = mop_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_BUSY: begin
                    acc_d = acc_nx;
                    lo_d  = lo_nx;
                    cnt_d = cnt_q - C_ONE;
                    if (cnt_q == C_ONE) begin
                        state_d = ST_DONE;
                        q_d     = m_res;
                        cmp_d   = 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready && !in_valid) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (accept) begin
                if (is_mop) begin
                    state_d = ST_BUSY;
                    mop_d   = S[4:2];
                    neg_d   = init_neg;
                    acc_d   = '0;
                    lo_d    = a_mag;
                    opnd_d  = b_mag;
                    cnt_d   = C_ITER;
                end else begin
                    state_d = ST_DONE;
                    q_d     = base_q;
                    cmp_d   = base_cmp;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cmp_q   <= 1'b0;
            cnt_q   <= '0;
            mop_q   <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            mop_q   <= mop_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Scoreboard bench for alu_seq (XLEN=32), directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [5:0]  S         = '0;
    logic [31:0] A         = '0;
    logic [31:0] B         = '0;
    logic        in_ready, out_valid, CMP, busy;
    logic [31:0] Q;

    int          total     = 0;
    int          bad       = 0;
    int          last_wait = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    alu_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .CMP       (CMP),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present an op (caller is just past a rising edge), wait for acceptance,
    // and optionally queue its expected result.
    task automatic issue(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic ec, input bit push);
        int waited;
        waited = 0;
        S = s; A = a; B = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        last_wait = waited;
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1 (S=%0d)", s);
        end else if (push) begin
            exp_q.push_back({eq, ec});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: every delivered result is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got Q=0x%08h CMP=%0b expected none", Q, CMP);
            end else begin
                mon_e = exp_q.pop_front();
                if ({Q, CMP} !== mon_e) begin
                    bad++;
                    $display("FAIL result: got Q=0x%08h CMP=%0b expected Q=0x%08h CMP=%0b",
                             Q, CMP, mon_e[32:1], mon_e[0]);
                end
            end
        end
    end

    initial begin
        int n, nb, hi;

        // ---------------- reset state ----------------
        #2;
        check("rst_Q", Q, 32'h0);
        check("rst_CMP", CMP, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        sync();

        // ---------------- base ops ----------------
        issue(6'd1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
        @(negedge clk);
        check("add_latency_out_valid", out_valid, 1);
        sync();
        issue(6'd33, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1);
        issue(6'd29, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
        issue(6'd25, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1);
        issue(6'd17, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
        issue(6'd5,  32'h1,         32'h24,        32'h10,        1'b0, 1);
        issue(6'd21, 32'h8000_0000, 32'h1F,        32'h1,         1'b0, 1);
        issue(6'd53, 32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0, 1);
        issue(6'd9,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b1, 1);
        issue(6'd9,  32'd5,         32'd5,         32'h0,         1'b0, 1);
        issue(6'd13, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1);
        issue(6'd63, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1);
        issue(6'd31, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1);
        issue(6'd7,  32'h1234,      32'h1234,      32'h0,         1'b0, 1);
        issue(6'd35, 32'h1234,      32'h1234,      32'h0,         1'b1, 1);
        issue(6'd19, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1);
        issue(6'd27, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1);
        issue(6'd55, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1);
        issue(6'd11, 32'h5,         32'h3,         32'h0,         1'b0, 1);
        issue(6'd0,  32'h5,         32'h3,         32'h0,         1'b0, 1);
        check("b2b_base_no_stall", last_wait, 0);
        drain();
        sync();

        // ---------------- MUL latency ----------------
        issue(6'd2, 32'd7, 32'd6, 32'd42, 1'b0, 1);
        n = 0; nb = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (out_valid) break;
        end
        check("mul_out_valid_cycle", n, 33);
        check("mul_busy_cycles", nb, 32);
        sync();

        // ---------------- multi-cycle vectors ----------------
        issue(6'd6,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1);
        issue(6'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);
        issue(6'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1);
        issue(6'd2,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0, 1);
        issue(6'd6,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 1'b0, 1);
        issue(6'd18, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1);
        issue(6'd26, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1);
        issue(6'd22, 32'h1234,      32'h0,         32'hFFFF_FFFF, 1'b0, 1);
        issue(6'd26, 32'd9,         32'h0,         32'd9,         1'b0, 1);
        issue(6'd26, 32'hFFFF_FFEC, 32'h0,         32'hFFFF_FFEC, 1'b0, 1);
        issue(6'd18, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 1'b0, 1);
        issue(6'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 1);
        issue(6'd22, 32'd100,       32'd7,         32'd14,        1'b0, 1);
        issue(6'd30, 32'd100,       32'd7,         32'd2,         1'b0, 1);
        issue(6'd18, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0, 1);
        issue(6'd26, 32'd20,        32'hFFFF_FFFD, 32'd2,         1'b0, 1);
        drain();
        sync();

        // ---------------- output back-pressure ----------------
        out_ready = 1'b0;
        issue(6'd1, 32'd3, 32'd4, 32'd7, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_Q", Q, 32'd7);
            check("hold_CMP", CMP, 0);
            check("hold_in_ready", in_ready, 0);
            A = $urandom;
            S = 6'd33;
        end
        sync();
        out_ready = 1'b1;
        issue(6'd1, 32'd10, 32'd20, 32'd30, 1'b0, 1);
        check("release_same_cycle_accept", last_wait, 0);
        @(negedge clk);
        check("release_next_out_valid", out_valid, 1);
        check("release_next_Q", Q, 32'd30);
        sync();

        // ---------------- flush mid-BUSY ----------------
        issue(6'd2, 32'd3, 32'd5, 32'd15, 1'b0, 0);
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", busy, 1);
        flush = 1'b1;
        sync();
        flush = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_Q_kept", Q, 32'd30);
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) hi++;
        end
        check("flush_no_result", hi, 0);
        sync();
        issue(6'd2, 32'd3, 32'd5, 32'd15, 1'b0, 1);
        drain();
        sync();

        // ---------------- reset mid-DIV ----------------
        issue(6'd18, 32'd100, 32'd7, 32'd14, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_Q", Q, 32'h0);
        check("arst_CMP", CMP, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sync();
        issue(6'd18, 32'd100, 32'd7, 32'd14, 1'b0, 1);
        issue(6'd1,  32'd1,   32'd2, 32'd3,  1'b0, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
